// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer with HI/LO pair for the execute stage.
// Result is formed at issue and committed after a fixed busy window.
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        readReq,
    input  logic        readSel,
    output logic [31:0] readData,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi, res_hi_d;
    logic [31:0] res_lo, res_lo_d;

    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] sa, sb_safe;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        ub_safe, quot_u, rem_u;
    logic               div0, ovf;
    logic [31:0]        calc_hi, calc_lo;

    // Zero and overflow divisors are swapped for 1 so the divider never
    // sees an undefined case; the overflow quotient then falls out as
    // 0x80000000 with remainder 0.
    always_comb begin
        prod_s  = {{32{operandA[31]}}, operandA}
                * {{32{operandB[31]}}, operandB};
        prod_u  = {32'd0, operandA} * {32'd0, operandB};
        div0    = (operandB == 32'd0);
        ovf     = (operandA == 32'h8000_0000)
               && (operandB == 32'hFFFF_FFFF);
        sa      = $signed(operandA);
        sb_safe = (div0 || ovf) ? 32'sd1 : $signed(operandB);
        quot_s  = sa / sb_safe;
        rem_s   = sa % sb_safe;
        ub_safe = div0 ? 32'd1 : operandB;
        quot_u  = operandA / ub_safe;
        rem_u   = operandA % ub_safe;
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        case (op)
            OP_MULT: begin
                calc_hi = prod_s[63:32];
                calc_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                calc_hi = prod_u[63:32];
                calc_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (div0) begin
                    calc_hi = operandA;
                    calc_lo = 32'hFFFF_FFFF;
                end else begin
                    calc_hi = rem_s;
                    calc_lo = quot_s;
                end
            end
            OP_DIVU: begin
                if (div0) begin
                    calc_hi = operandA;
                    calc_lo = 32'hFFFF_FFFF;
                end else begin
                    calc_hi = rem_u;
                    calc_lo = quot_u;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi;
        res_lo_d = res_lo;
        unique case (state)
            IDLE: begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        res_hi_d = calc_hi;
                        res_lo_d = calc_lo;
                        cnt_d    = MUL_N;
                        state_d  = RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        res_hi_d = calc_hi;
                        res_lo_d = calc_lo;
                        cnt_d    = DIV_N;
                        state_d  = RUN;
                    end
                    OP_MTHI: hi_d = operandA;
                    OP_MTLO: lo_d = operandA;
                    default: ;
                endcase
            end
            RUN: begin
                if (cnt <= 4'd1) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            res_hi <= res_hi_d;
            res_lo <= res_lo_d;
        end
    end

    assign busy     = (state == RUN);
    assign stall    = busy
                   && (((op != OP_NONE) && (op != OP_RSVD)) || readReq);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign readData = readSel ? hi_q : lo_q;

endmodule
